// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the data-memory load/store interface.
package cpu_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 8;
  localparam int unsigned DMEM_DATA_W    = 32;
  localparam int unsigned DMEM_RD_LAT    = 2;

  typedef struct packed {
    logic                      we;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [3:0]                be;
    logic [DMEM_DATA_W-1:0]    wdata;
  } dmem_req_t;

  typedef struct packed {
    logic [DMEM_DATA_W-1:0] rdata;
    logic                   is_wr;
    logic                   err;
  } dmem_rsp_t;

  // Replace only the byte lanes selected by be.
  function automatic logic [DMEM_DATA_W-1:0] be_merge(
    input logic [DMEM_DATA_W-1:0] old_word,
    input logic [DMEM_DATA_W-1:0] new_word,
    input logic [3:0]             be
  );
    logic [DMEM_DATA_W-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// In-order synchronous FIFO of data-memory responses; head is visible
// combinationally on rdata_o whenever empty_o is low.
module resp_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  dmem_rsp_t wdata_i,
  input  logic      pop_i,
  output dmem_rsp_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  dmem_rsp_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: owns the data array, serves in-order load/store
// requests with fixed latency and buffers responses against backpressure.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned RD_LAT = DMEM_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_is_wr,
  output logic              rsp_err
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OUT_MAX = RD_LAT + 1;
  localparam int unsigned CNT_W   = $clog2(OUT_MAX + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              acc, in_range;
  dmem_rsp_t         new_rsp, push_rsp, head;
  logic              push, pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Extra bit so DEPTH == 2**ADDR_W still compares correctly.
  assign in_range  = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
  assign idx       = req_addr[IDX_W-1:0];
  assign req_ready = (cnt_q < CNT_W'(OUT_MAX)) && !fifo_full;
  assign acc       = req_valid && req_ready && !rst;

  always_comb begin
    new_rsp       = '0;
    new_rsp.is_wr = req_we;
    new_rsp.err   = !in_range;
    if (!req_we && in_range) new_rsp.rdata = mem_q[idx];
  end

  always_ff @(posedge clk) begin
    if (acc && req_we && in_range) mem_q[idx] <= be_merge(mem_q[idx], req_wdata, req_be);
  end

  // The array read happens at the accept edge; the pipe supplies the rest of the latency.
  if (RD_LAT == 1) begin : g_direct
    assign push     = acc;
    assign push_rsp = new_rsp;
  end else begin : g_pipe
    localparam int unsigned NSTG = RD_LAT - 1;
    logic      vld_q [NSTG];
    dmem_rsp_t rsp_q [NSTG];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < NSTG; i++) vld_q[i] <= 1'b0;
      end else begin
        vld_q[0] <= acc;
        for (int unsigned i = 1; i < NSTG; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      rsp_q[0] <= new_rsp;
      for (int unsigned i = 1; i < NSTG; i++) rsp_q[i] <= rsp_q[i-1];
    end

    assign push     = vld_q[NSTG-1];
    assign push_rsp = rsp_q[NSTG-1];
  end

  resp_fifo #(
    .DEPTH(OUT_MAX)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (push),
    .wdata_i(push_rsp),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? head.rdata : '0;
  assign rsp_is_wr = rsp_valid && head.is_wr;
  assign rsp_err   = rsp_valid && head.err;

  always_comb begin
    cnt_d = cnt_q;
    case ({acc, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
